// File: rtl/bsg_cache_pkg.sv
// Shared cache-side declarations: DMA packet width helper used by DMA endpoints.
package bsg_cache_pkg;

    // A DMA packet is {write_not_read, addr}; one flag bit plus the byte address.
    function automatic int unsigned bsg_cache_dma_pkt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bsg_cache_dma_responder_mem.sv
// Backing store for the DMA responder: asynchronous read, synchronous write.
module bsg_cache_dma_responder_mem #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 1024,
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Word write; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_cache_dma_responder.sv
// Memory-side endpoint of the bsg_cache DMA interface: services block fill
// (read) and evict (write) packets from an internal word-addressed store.
module bsg_cache_dma_responder
    import bsg_cache_pkg::*;
#(
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned data_width_p          = 32,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned mem_els_p             = 1024,
    parameter int unsigned latency_p             = 4
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,

    input  logic [bsg_cache_dma_pkt_width(addr_width_p)-1:0] dma_pkt_i,
    input  logic                                            dma_pkt_v_i,
    output logic                                            dma_pkt_yumi_o,

    output logic [data_width_p-1:0]                         dma_data_o,
    output logic                                            dma_data_v_o,
    input  logic                                            dma_data_ready_i,

    input  logic [data_width_p-1:0]                         dma_data_i,
    input  logic                                            dma_data_v_i,
    output logic                                            dma_data_yumi_o
);

    localparam int unsigned byte_offset_lp    = $clog2(data_width_p / 8);
    localparam int unsigned block_offset_lp   = $clog2(block_size_in_words_p);
    localparam int unsigned beat_width_lp     = (block_offset_lp == 0) ? 1 : block_offset_lp;
    localparam int unsigned mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int unsigned lat_width_lp      = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [beat_width_lp-1:0]     beat_last_lp  = beat_width_lp'(block_size_in_words_p - 1);
    localparam logic [lat_width_lp-1:0]      lat_last_lp   = (latency_p > 0) ? lat_width_lp'(latency_p - 1) : '0;
    localparam logic [mem_addr_width_lp-1:0] block_mask_lp = ~mem_addr_width_lp'(block_size_in_words_p - 1);

    typedef struct packed {
        logic                    write_not_read;
        logic [addr_width_p-1:0] addr;
    } dma_pkt_s;

    typedef enum logic [1:0] {
        e_idle,
        e_wait,
        e_read,
        e_write
    } state_e;

    state_e                        state_r, state_n;
    logic [beat_width_lp-1:0]      beat_r, beat_n;
    logic [lat_width_lp-1:0]       lat_r, lat_n;
    logic [mem_addr_width_lp-1:0]  base_r, base_n;
    logic                          wnr_r, wnr_n;

    dma_pkt_s                      pkt;
    logic [mem_addr_width_lp-1:0]  pkt_base;
    logic [mem_addr_width_lp-1:0]  mem_addr;
    logic                          mem_w_v;

    assign pkt = dma_pkt_i;

    // Byte address -> word index, truncated to the store depth, block aligned.
    assign pkt_base = mem_addr_width_lp'(pkt.addr >> byte_offset_lp) & block_mask_lp;

    // Base is block aligned, so adding the beat never carries out of the block.
    assign mem_addr = base_r + mem_addr_width_lp'(beat_r);

    bsg_cache_dma_responder_mem #(
        .width_p (data_width_p),
        .els_p   (mem_els_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (mem_addr),
        .w_data_i (dma_data_i),
        .r_addr_i (mem_addr),
        .r_data_o (dma_data_o)
    );

    // State, counter and packet-field registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            beat_r  <= '0;
            lat_r   <= '0;
            base_r  <= '0;
            wnr_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            beat_r  <= beat_n;
            lat_r   <= lat_n;
            base_r  <= base_n;
            wnr_r   <= wnr_n;
        end
    end

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        state_n         = state_r;
        beat_n          = beat_r;
        lat_n           = lat_r;
        base_n          = base_r;
        wnr_n           = wnr_r;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_w_v         = 1'b0;

        unique case (state_r)
            e_idle: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    base_n = pkt_base;
                    wnr_n  = pkt.write_not_read;
                    beat_n = '0;
                    lat_n  = '0;
                    if (latency_p > 0) begin
                        state_n = e_wait;
                    end else begin
                        state_n = pkt.write_not_read ? e_write : e_read;
                    end
                end
            end

            e_wait: begin
                lat_n = lat_r + lat_width_lp'(1);
                if (lat_r == lat_last_lp) begin
                    lat_n   = '0;
                    state_n = wnr_r ? e_write : e_read;
                end
            end

            e_read: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_i) begin
                    beat_n = beat_r + beat_width_lp'(1);
                    if (beat_r == beat_last_lp) begin
                        beat_n  = '0;
                        state_n = e_idle;
                    end
                end
            end

            e_write: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    mem_w_v = 1'b1;
                    beat_n  = beat_r + beat_width_lp'(1);
                    if (beat_r == beat_last_lp) begin
                        beat_n  = '0;
                        state_n = e_idle;
                    end
                end
            end

            default: state_n = e_idle;
        endcase

        // Reset must suppress handshakes even while the state register is
        // still mid-transfer, so an aborting reset drops the pending beat.
        if (reset_i) begin
            dma_pkt_yumi_o  = 1'b0;
            dma_data_v_o    = 1'b0;
            dma_data_yumi_o = 1'b0;
            mem_w_v         = 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_cache_dma_responder.sv
// Self-checking bench for bsg_cache_dma_responder (latency 4 and latency 0).
module tb_bsg_cache_dma_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned BLK = 8;
    localparam int unsigned ELS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [32:0] pkt;
    logic        pkt_v, pkt_yumi;
    logic [31:0] data_o;
    logic        data_v_o, ready;
    logic [31:0] data_in;
    logic        data_v_in, data_yumi;

    logic [32:0] z_pkt;
    logic        z_pkt_v, z_pkt_yumi;
    logic [31:0] z_data_o;
    logic        z_data_v_o, z_ready;
    logic [31:0] z_data_in;
    logic        z_data_v_in, z_data_yumi;

    bsg_cache_dma_responder #(
        .addr_width_p          (32),
        .data_width_p          (32),
        .block_size_in_words_p (BLK),
        .mem_els_p             (ELS),
        .latency_p             (LAT)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .dma_pkt_i        (pkt),
        .dma_pkt_v_i      (pkt_v),
        .dma_pkt_yumi_o   (pkt_yumi),
        .dma_data_o       (data_o),
        .dma_data_v_o     (data_v_o),
        .dma_data_ready_i (ready),
        .dma_data_i       (data_in),
        .dma_data_v_i     (data_v_in),
        .dma_data_yumi_o  (data_yumi)
    );

    bsg_cache_dma_responder #(
        .addr_width_p          (32),
        .data_width_p          (32),
        .block_size_in_words_p (BLK),
        .mem_els_p             (ELS),
        .latency_p             (0)
    ) dut_z (
        .clk_i            (clk),
        .reset_i          (reset),
        .dma_pkt_i        (z_pkt),
        .dma_pkt_v_i      (z_pkt_v),
        .dma_pkt_yumi_o   (z_pkt_yumi),
        .dma_data_o       (z_data_o),
        .dma_data_v_o     (z_data_v_o),
        .dma_data_ready_i (z_ready),
        .dma_data_i       (z_data_in),
        .dma_data_v_i     (z_data_v_in),
        .dma_data_yumi_o  (z_data_yumi)
    );

    // Reference model: plain word array indexed by the aligned word index.
    logic [31:0] model [ELS];
    logic [31:0] wbuf [BLK];
    logic [31:0] zbuf [BLK];
    logic [31:0] rand_addr [4];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned blk_base(input logic [31:0] addr);
        return ((addr / 4) % ELS) / BLK * BLK;
    endfunction

    task automatic do_write(input logic [31:0] addr, input bit gaps);
        int unsigned base;
        int          i;
        int          cyc;
        bit          v;
        base = blk_base(addr);
        i    = 0;
        cyc  = 0;
        data_v_in = 1'b1;
        data_in   = wbuf[0];
        pkt       = {1'b1, addr};
        pkt_v     = 1'b1;
        #1;
        check("wr_pkt_yumi", 64'(pkt_yumi), 64'(1));
        check("wr_idle_data_yumi", 64'(data_yumi), 64'(0));
        tick();
        for (int w = 0; w < LAT; w++) begin
            #1;
            check("wr_wait_data_yumi", 64'(data_yumi), 64'(0));
            check("wr_wait_pkt_ignored", 64'(pkt_yumi), 64'(0));
            tick();
        end
        pkt_v = 1'b0;
        while (i < BLK && cyc < 64) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_v_in = v;
            data_in   = wbuf[i];
            #1;
            check("wr_beat_yumi", 64'(data_yumi), 64'(v));
            if (v) begin
                model[base + i] = wbuf[i];
                i++;
            end
            tick();
            cyc++;
        end
        check("wr_beat_count", 64'(i), 64'(BLK));
        data_v_in = 1'b1;
        #1;
        check("wr_done_idle_yumi", 64'(data_yumi), 64'(0));
        data_v_in = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int mode);
        int unsigned base;
        int          i;
        int          cyc;
        bit          r;
        base  = blk_base(addr);
        i     = 0;
        cyc   = 0;
        ready = 1'b0;
        pkt   = {1'b0, addr};
        pkt_v = 1'b1;
        #1;
        check("rd_pkt_yumi", 64'(pkt_yumi), 64'(1));
        check("rd_idle_v", 64'(data_v_o), 64'(0));
        tick();
        for (int w = 0; w < LAT; w++) begin
            #1;
            check("rd_wait_v", 64'(data_v_o), 64'(0));
            check("rd_wait_pkt_ignored", 64'(pkt_yumi), 64'(0));
            tick();
        end
        pkt_v = 1'b0;
        while (i < BLK && cyc < 64) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            #1;
            check("rd_v", 64'(data_v_o), 64'(1));
            check("rd_data", 64'(data_o), 64'(model[base + i]));
            if (r) i++;
            tick();
            cyc++;
        end
        check("rd_beat_count", 64'(i), 64'(BLK));
        #1;
        check("rd_done_idle_v", 64'(data_v_o), 64'(0));
        ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pkt = '0;   pkt_v = 1'b1;   ready = 1'b0;   data_in = '0;   data_v_in = 1'b1;
        z_pkt = '0; z_pkt_v = 1'b1; z_ready = 1'b0; z_data_in = '0; z_data_v_in = 1'b1;
        tick();
        tick();
        // Handshakes suppressed while reset is high, even with valids asserted.
        check("rst_pkt_yumi", 64'(pkt_yumi), 64'(0));
        check("rst_data_v", 64'(data_v_o), 64'(0));
        check("rst_data_yumi", 64'(data_yumi), 64'(0));
        check("rst_z_pkt_yumi", 64'(z_pkt_yumi), 64'(0));
        reset = 1'b0;
        pkt_v = 1'b0; data_v_in = 1'b0;
        z_pkt_v = 1'b0; z_data_v_in = 1'b0;
        tick();
        #1;
        check("idle_pkt_yumi", 64'(pkt_yumi), 64'(0));
        check("idle_data_v", 64'(data_v_o), 64'(0));
        check("idle_data_yumi", 64'(data_yumi), 64'(0));

        // Write 0xA0..0xA7 to 0x40, read back, mid-block and aliased reads.
        for (int i = 0; i < BLK; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(32'h40, 1'b0);
        do_read(32'h40, 0);
        do_read(32'h4C, 0);
        do_read(32'h40, 1);
        do_read(32'(ELS * 4) + 32'h40, 2);

        // Randomized blocks with write-data gaps and random backpressure.
        for (int k = 0; k < 4; k++) begin
            rand_addr[k] = $urandom;
            for (int i = 0; i < BLK; i++) wbuf[i] = $urandom;
            do_write(rand_addr[k], 1'b1);
        end
        for (int k = 3; k >= 0; k--) do_read(rand_addr[k], 2);

        // Abort: reset after 3 write beats to 0x40 keeps those 3 words only.
        do_write(32'h40, 1'b0);
        for (int i = 0; i < BLK; i++) wbuf[i] = 32'hB0 + 32'(i);
        pkt = {1'b1, 32'h40};
        pkt_v = 1'b1;
        data_v_in = 1'b1;
        data_in = wbuf[0];
        #1;
        check("abort_pkt_yumi", 64'(pkt_yumi), 64'(1));
        tick();
        pkt_v = 1'b0;
        for (int w = 0; w < LAT; w++) tick();
        for (int i = 0; i < 3; i++) begin
            data_in = wbuf[i];
            #1;
            check("abort_beat_yumi", 64'(data_yumi), 64'(1));
            model[blk_base(32'h40) + i] = wbuf[i];
            tick();
        end
        reset = 1'b1;
        data_in = wbuf[3];
        #1;
        check("abort_reset_yumi", 64'(data_yumi), 64'(0));
        tick();
        reset = 1'b0;
        data_v_in = 1'b0;
        #1;
        check("abort_idle_v", 64'(data_v_o), 64'(0));
        do_read(32'h40, 0);

        // Latency 0: early write data waits, first beat right after packet yumi.
        for (int i = 0; i < BLK; i++) zbuf[i] = $urandom;
        z_data_v_in = 1'b1;
        z_data_in = zbuf[0];
        #1;
        check("z_early_yumi", 64'(z_data_yumi), 64'(0));
        tick();
        z_pkt = {1'b1, 32'h80};
        z_pkt_v = 1'b1;
        #1;
        check("z_wr_pkt_yumi", 64'(z_pkt_yumi), 64'(1));
        check("z_wr_pkt_cycle_yumi", 64'(z_data_yumi), 64'(0));
        tick();
        z_pkt_v = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            z_data_in = zbuf[i];
            #1;
            check("z_wr_beat_yumi", 64'(z_data_yumi), 64'(1));
            tick();
        end
        #1;
        check("z_wr_done_yumi", 64'(z_data_yumi), 64'(0));
        z_data_v_in = 1'b0;
        z_pkt = {1'b0, 32'h80};
        z_pkt_v = 1'b1;
        z_ready = 1'b1;
        #1;
        check("z_rd_pkt_yumi", 64'(z_pkt_yumi), 64'(1));
        check("z_rd_pkt_cycle_v", 64'(z_data_v_o), 64'(0));
        tick();
        z_pkt_v = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            #1;
            check("z_rd_v", 64'(z_data_v_o), 64'(1));
            check("z_rd_data", 64'(z_data_o), 64'(zbuf[i]));
            tick();
        end
        #1;
        check("z_rd_done_v", 64'(z_data_v_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
